// File: rtl/column_l1route_sched.sv
// Round-robin burst scheduler for the shared column-wise L1 route (QSN permuters behind a 2:1 mux).
// Optional build macro COL_L1ROUTE_ERRCHK_EN adds the sticky err_o diagnostic output.
module column_l1route_sched #(
    parameter int STRIDE_UNIT_SIZE      = 15,
    parameter int BITWIDTH_SHIFT_FACTOR = $clog2(STRIDE_UNIT_SIZE - 1),
    parameter int BURST_LEN             = 3,
    parameter int PIPE_LATENCY          = 2,
    parameter int CNT_WIDTH             = $clog2(BURST_LEN + 1)
) (
    input  logic                             sys_clk,
    input  logic                             rstn,
    input  logic                             ch_req_i,
    input  logic [BITWIDTH_SHIFT_FACTOR-1:0] ch_shift_i,
    output logic                             ch_gnt_o,
    input  logic                             vnu_req_i,
    input  logic [BITWIDTH_SHIFT_FACTOR-1:0] vnu_shift_i,
    output logic                             vnu_gnt_o,
    output logic                             sw_in_src_o,
    output logic [BITWIDTH_SHIFT_FACTOR-1:0] shift_factor_o,
    output logic                             route_valid_o,
    output logic                             route_src_o,
    output logic                             route_last_o,
    output logic                             busy_o
`ifdef COL_L1ROUTE_ERRCHK_EN
    ,
    output logic                             err_o
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BURST_CH  = 2'd1,
        BURST_VNU = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

    state_e                             state_q, state_d;
    logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;
    logic                               last_served_q, last_served_d;
    logic                               src_q, src_d;
    logic [BITWIDTH_SHIFT_FACTOR-1:0]   shift_q, shift_d;

    logic [PIPE_LATENCY-1:0]            pv_q, pv_d;
    logic [PIPE_LATENCY-1:0]            ps_q, ps_d;
    logic [PIPE_LATENCY-1:0]            pl_q, pl_d;

    logic                               any_req;
    logic                               last_beat;
    logic                               arb_last_served;
    logic                               next_is_vnu;
    logic                               start;
    logic [BITWIDTH_SHIFT_FACTOR-1:0]   sel_shift;

    function automatic logic shift_out_of_range(input logic [BITWIDTH_SHIFT_FACTOR-1:0] s);
        return (32'(s) >= 32'(STRIDE_UNIT_SIZE));
    endfunction

    function automatic logic [BITWIDTH_SHIFT_FACTOR-1:0] clamp_shift(
        input logic [BITWIDTH_SHIFT_FACTOR-1:0] s);
        if (shift_out_of_range(s)) begin
            return '0;
        end
        return s;
    endfunction

    // Returns 1 when the VNU should own the next burst (only meaningful if a request is pending).
    function automatic logic pick_vnu(input logic ch, input logic vnu, input logic ls_vnu);
        if (ch && vnu) begin
            return ~ls_vnu;
        end
        return vnu;
    endfunction

    assign any_req   = ch_req_i | vnu_req_i;
    assign last_beat = (state_q != IDLE) && (cnt_q == LAST_BEAT);
    // On the final beat the current owner already counts as last served for the next pick.
    assign arb_last_served = last_beat ? (state_q == BURST_VNU) : last_served_q;
    assign next_is_vnu     = pick_vnu(ch_req_i, vnu_req_i, arb_last_served);
    assign sel_shift       = next_is_vnu ? vnu_shift_i : ch_shift_i;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_served_d = last_served_q;
        src_d         = src_q;
        shift_d       = shift_q;
        start         = 1'b0;

        unique case (state_q)
            IDLE: begin
                start = any_req;
            end
            BURST_CH, BURST_VNU: begin
                if (last_beat) begin
                    last_served_d = (state_q == BURST_VNU);
                    start         = any_req;
                    if (!any_req) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        src_d   = 1'b0;
                        shift_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                src_d   = 1'b0;
                shift_d = '0;
            end
        endcase

        if (start) begin
            state_d = next_is_vnu ? BURST_VNU : BURST_CH;
            cnt_d   = '0;
            src_d   = next_is_vnu;
            shift_d = clamp_shift(sel_shift);
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_served_q <= 1'b1;
            src_q         <= 1'b0;
            shift_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_served_q <= last_served_d;
            src_q         <= src_d;
            shift_q       <= shift_d;
        end
    end

    // Tag pipeline mirrors the QSN latency: stage 0 captures the beat being granted now.
    generate
        if (PIPE_LATENCY == 1) begin : g_pipe1
            assign pv_d = state_q != IDLE;
            assign ps_d = src_q;
            assign pl_d = last_beat;
        end else begin : g_pipeN
            assign pv_d = {pv_q[PIPE_LATENCY-2:0], state_q != IDLE};
            assign ps_d = {ps_q[PIPE_LATENCY-2:0], src_q};
            assign pl_d = {pl_q[PIPE_LATENCY-2:0], last_beat};
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            pv_q <= '0;
            ps_q <= '0;
            pl_q <= '0;
        end else begin
            pv_q <= pv_d;
            ps_q <= ps_d;
            pl_q <= pl_d;
        end
    end

    assign ch_gnt_o       = (state_q == BURST_CH);
    assign vnu_gnt_o      = (state_q == BURST_VNU);
    assign sw_in_src_o    = src_q;
    assign shift_factor_o = shift_q;
    assign route_valid_o  = pv_q[PIPE_LATENCY-1];
    assign route_src_o    = ps_q[PIPE_LATENCY-1];
    assign route_last_o   = pl_q[PIPE_LATENCY-1];
    assign busy_o         = (state_q != IDLE) || (|pv_q);

`ifdef COL_L1ROUTE_ERRCHK_EN
    logic oor_q, oor_d;
    logic err_q, err_d;

    // oor_q pulses during the first beat of a clamped burst; err_q latches it one cycle later.
    assign oor_d = start && shift_out_of_range(sel_shift);
    assign err_d = err_q | oor_q | (ch_gnt_o & vnu_gnt_o);

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            oor_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            oor_q <= oor_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_column_l1route_sched.sv
// Self-checking bench for column_l1route_sched: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_column_l1route_sched;

    localparam int SU = 15;
    localparam int SW = 4;
    localparam int BL = 3;
    localparam int PL = 2;

    logic          sys_clk = 1'b0;
    logic          rstn;
    logic          ch_req_i, vnu_req_i;
    logic [SW-1:0] ch_shift_i, vnu_shift_i;
    logic          ch_gnt_o, vnu_gnt_o, sw_in_src_o;
    logic [SW-1:0] shift_factor_o;
    logic          route_valid_o, route_src_o, route_last_o, busy_o;
`ifdef COL_L1ROUTE_ERRCHK_EN
    logic          err_o;
`endif

    always #5 sys_clk = ~sys_clk;

    column_l1route_sched #(
        .STRIDE_UNIT_SIZE(SU),
        .BURST_LEN(BL),
        .PIPE_LATENCY(PL)
    ) dut (
        .sys_clk(sys_clk),
        .rstn(rstn),
        .ch_req_i(ch_req_i),
        .ch_shift_i(ch_shift_i),
        .ch_gnt_o(ch_gnt_o),
        .vnu_req_i(vnu_req_i),
        .vnu_shift_i(vnu_shift_i),
        .vnu_gnt_o(vnu_gnt_o),
        .sw_in_src_o(sw_in_src_o),
        .shift_factor_o(shift_factor_o),
        .route_valid_o(route_valid_o),
        .route_src_o(route_src_o),
        .route_last_o(route_last_o),
        .busy_o(busy_o)
`ifdef COL_L1ROUTE_ERRCHK_EN
        ,
        .err_o(err_o)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] outs();
        return {ch_gnt_o, vnu_gnt_o, sw_in_src_o, shift_factor_o,
                route_valid_o, route_src_o, route_last_o, busy_o};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // ---------------- reference model (burst ownership + delayed tag queue) ----------------
    typedef struct packed { bit v; bit s; bit l; } tag_t;
    int            m_owner;      // 0 none, 1 channel, 2 VNU
    int            m_beat;
    bit            m_ls_vnu;
    bit            m_src;
    logic [SW-1:0] m_shift;
    tag_t          m_pipe[$];

    function automatic void model_reset();
        m_owner  = 0;
        m_beat   = 0;
        m_ls_vnu = 1'b1;
        m_src    = 1'b0;
        m_shift  = '0;
        m_pipe.delete();
        for (int i = 0; i < PL; i++) m_pipe.push_back('0);
    endfunction

    function automatic void model_step();
        tag_t t;
        int   nxt;
        t.v = (m_owner != 0);
        t.s = m_src;
        t.l = (m_owner != 0) && (m_beat == BL - 1);
        m_pipe.push_front(t);
        void'(m_pipe.pop_back());
        if (m_owner == 0 || m_beat == BL - 1) begin
            if (m_owner != 0) m_ls_vnu = (m_owner == 2);
            nxt = 0;
            if (ch_req_i && vnu_req_i) nxt = m_ls_vnu ? 1 : 2;
            else if (ch_req_i)         nxt = 1;
            else if (vnu_req_i)        nxt = 2;
            m_owner = nxt;
            m_beat  = 0;
            if (nxt == 0) begin
                m_src   = 1'b0;
                m_shift = '0;
            end else begin
                logic [SW-1:0] s;
                s       = (nxt == 2) ? vnu_shift_i : ch_shift_i;
                m_src   = (nxt == 2);
                m_shift = (int'(s) >= SU) ? '0 : s;
            end
        end else begin
            m_beat++;
        end
    endfunction

    function automatic logic [10:0] m_outs();
        bit busy;
        busy = (m_owner != 0);
        foreach (m_pipe[i]) if (m_pipe[i].v) busy = 1'b1;
        return {m_owner == 1, m_owner == 2, m_src, m_shift,
                m_pipe[PL-1].v, m_pipe[PL-1].s, m_pipe[PL-1].l, busy};
    endfunction

    task automatic do_reset();
        ch_req_i    = 1'b0;
        vnu_req_i   = 1'b0;
        ch_shift_i  = '0;
        vnu_shift_i = '0;
        rstn        = 1'b0;
        #1;
        cmp("reset_async", 32'(outs()), 32'd0);
        tick();
        cmp("reset_hold", 32'(outs()), 32'd0);
`ifdef COL_L1ROUTE_ERRCHK_EN
        cmp("reset_err", 32'(err_o), 32'd0);
`endif
        rstn = 1'b1;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            rst;
        bit            chr;
        logic [SW-1:0] chs;
        bit            vr;
        logic [SW-1:0] vs;
        logic [10:0]   exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit rst, input bit chr, input int chs, input bit vr, input int vs,
                       input bit gc, input bit gv, input bit src, input int sh,
                       input bit rv, input bit rs, input bit rl, input bit busy);
        vec_t v;
        v.rst = rst;
        v.chr = chr;
        v.chs = SW'(chs);
        v.vr  = vr;
        v.vs  = SW'(vs);
        v.exp = {gc, gv, src, SW'(sh), rv, rs, rl, busy};
        tbl.push_back(v);
    endtask

    initial begin
        int cnt;
        rstn        = 1'b0;
        ch_req_i    = 1'b0;
        vnu_req_i   = 1'b0;
        ch_shift_i  = '0;
        vnu_shift_i = '0;
        #2;
        do_reset();

        //    rst chr chs vr vs   gc gv src sh  rv rs rl busy
        // single channel burst, shift 5
        add(1, 1, 5, 0, 0,   1, 0, 0, 5,  0, 0, 0, 1);
        add(0, 0, 5, 0, 0,   1, 0, 0, 5,  0, 0, 0, 1);
        add(0, 0, 5, 0, 0,   1, 0, 0, 5,  1, 0, 0, 1);
        add(0, 0, 5, 0, 0,   0, 0, 0, 0,  1, 0, 0, 1);
        add(0, 0, 5, 0, 0,   0, 0, 0, 0,  1, 0, 1, 1);
        add(0, 0, 5, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0);
        // contention from reset: CH, VNU, CH with no bubble, then drain
        add(1, 1, 3, 1, 9,   1, 0, 0, 3,  0, 0, 0, 1);
        add(0, 1, 3, 1, 9,   1, 0, 0, 3,  0, 0, 0, 1);
        add(0, 1, 3, 1, 9,   1, 0, 0, 3,  1, 0, 0, 1);
        add(0, 1, 3, 1, 9,   0, 1, 1, 9,  1, 0, 0, 1);
        add(0, 1, 3, 1, 9,   0, 1, 1, 9,  1, 0, 1, 1);
        add(0, 1, 3, 1, 9,   0, 1, 1, 9,  1, 1, 0, 1);
        add(0, 1, 3, 1, 9,   1, 0, 0, 3,  1, 1, 0, 1);
        add(0, 1, 3, 1, 9,   1, 0, 0, 3,  1, 1, 1, 1);
        add(0, 0, 3, 0, 9,   1, 0, 0, 3,  1, 0, 0, 1);
        add(0, 0, 3, 0, 9,   0, 0, 0, 0,  1, 0, 0, 1);
        add(0, 0, 3, 0, 9,   0, 0, 0, 0,  1, 0, 1, 1);
        add(0, 0, 3, 0, 9,   0, 0, 0, 0,  0, 0, 0, 0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            ch_req_i    = tbl[i].chr;
            ch_shift_i  = tbl[i].chs;
            vnu_req_i   = tbl[i].vr;
            vnu_shift_i = tbl[i].vs;
            tick();
            cmp($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // mid-burst request drop
        do_reset();
        ch_req_i   = 1'b1;
        ch_shift_i = 4'd6;
        tick();
        ch_req_i = 1'b0;
        cnt = int'(ch_gnt_o);
        for (int i = 0; i < 6; i++) begin
            tick();
            cnt += int'(ch_gnt_o);
        end
        cmp("drop_gnt_len", 32'(cnt), 32'd3);
        cmp("drop_idle_ctrl", 32'({ch_gnt_o, vnu_gnt_o, sw_in_src_o, shift_factor_o}), 32'd0);
        cmp("drop_busy", 32'(busy_o), 32'd0);

        // out-of-range VNU shift
        vnu_req_i   = 1'b1;
        vnu_shift_i = 4'd15;
        tick();
        vnu_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmp("oor_gnt_shift", 32'({vnu_gnt_o, sw_in_src_o, shift_factor_o}), 32'({1'b1, 1'b1, 4'd0}));
`ifdef COL_L1ROUTE_ERRCHK_EN
            cmp("oor_err", 32'(err_o), (i == 0) ? 32'd0 : 32'd1);
`endif
            tick();
        end
        for (int i = 0; i < 3; i++) tick();
        cmp("oor_done", 32'(outs()), 32'd0);
`ifdef COL_L1ROUTE_ERRCHK_EN
        cmp("oor_err_sticky", 32'(err_o), 32'd1);
`endif

        // back-to-back VNU bursts with a shift change during the first
        vnu_req_i   = 1'b1;
        vnu_shift_i = 4'd4;
        tick();
        vnu_shift_i = 4'd7;
        for (int i = 0; i < 6; i++) begin
            cmp($sformatf("b2b_beat%0d", i), 32'({vnu_gnt_o, shift_factor_o}),
                32'({1'b1, (i < 3) ? 4'd4 : 4'd7}));
            tick();
        end
        vnu_req_i = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // asynchronous reset on the second beat of a VNU burst
        do_reset();
        vnu_req_i   = 1'b1;
        vnu_shift_i = 4'd2;
        tick();
        vnu_req_i = 1'b0;
        tick();
        cmp("rstmid_pre", 32'({vnu_gnt_o, shift_factor_o}), 32'({1'b1, 4'd2}));
        #2;
        rstn = 1'b0;
        #1;
        cmp("rstmid_async", 32'(outs()), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            cmp("rstmid_hold", 32'(outs()), 32'd0);
        end
        rstn      = 1'b1;
        ch_req_i  = 1'b1;
        vnu_req_i = 1'b1;
        tick();
        cmp("rstmid_ch_first", 32'({ch_gnt_o, vnu_gnt_o}), 32'b10);
        cmp("rstmid_no_stale", 32'(route_valid_o), 32'd0);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int dens;
            dens = 1 + 3 * ((i / 250) % 4);
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                ch_req_i    = ($urandom_range(0, 11) < dens);
                vnu_req_i   = ($urandom_range(0, 11) < dens);
                ch_shift_i  = SW'($urandom_range(0, 15));
                vnu_shift_i = SW'($urandom_range(0, 15));
                model_step();
                tick();
                cmp("random", 32'(outs()), 32'(m_outs()));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
